// File: rtl/mem_pkg.sv
// Shared memory-port definitions: size encodings, FSM state codes, and the lane
// steering helpers that are reused by the CPU load path.
package mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;
  localparam state_t ST_ERR  = 2'd3;

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      MEM_BYTE: lane_be = 4'b0001 << lane;
      MEM_HALF: lane_be = lane[1] ? 4'b1100 : 4'b0011;
      MEM_WORD: lane_be = 4'b1111;
      default:  lane_be = 4'b0000;
    endcase
  endfunction

  // Replicate right-justified store data onto every lane it could land in.
  function automatic logic [31:0] store_align(input logic [31:0] wd, input logic [1:0] sz);
    case (sz)
      MEM_BYTE: store_align = {4{wd[7:0]}};
      MEM_HALF: store_align = {2{wd[15:0]}};
      default:  store_align = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      MEM_BYTE: load_extract = {{24{~uns & b[7]}}, b};
      MEM_HALF: load_extract = {{16{~uns & h[15]}}, h};
      default:  load_extract = word;
    endcase
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM with per-byte write enables and registered read (read-first).
// No reset so it maps onto block RAM.
module mem_array #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] i_addr,
  input  logic [3:0]    i_we,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, programmable wait states,
// byte/half/word lane steering and a one-cycle error pulse for bad requests.
module mem_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        error
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT     = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [31:0]   r_rdata;
  logic [AW-1:0] r_idx;
  logic [1:0]    r_lane;
  logic [31:0]   r_wdata;
  logic [1:0]    r_size;
  logic          r_uns;
  logic          r_write;

  logic          w_req;
  logic          w_bad;
  logic [31:0]   w_off;
  logic          w_idle;
  logic          w_go_resp;
  logic          w_cur_write;
  logic [1:0]    w_cur_size;
  logic [1:0]    w_cur_lane;
  logic [31:0]   w_cur_wdata;
  logic [AW-1:0] w_ram_idx;
  logic [3:0]    w_we;
  logic [31:0]   w_ram_q;
  logic [31:0]   w_ld_data;

  assign w_req  = mem_read | mem_write;
  assign w_off  = addr - BASE_ADDR;
  assign w_idle = (r_state == ST_IDLE);
  assign w_bad  = (mem_read & mem_write)
                | (size == 2'b11)
                | ((size == MEM_HALF) & addr[0])
                | ((size == MEM_WORD) & (addr[1:0] != 2'b00))
                | ({1'b0, w_off} >= LIMIT);

  // With zero wait states the commit happens on the accepting edge, so the RAM
  // must see the raw request; otherwise it sees the latched copy.
  assign w_go_resp   = (w_idle & w_req & ~w_bad & (WAIT_CYCLES == 0))
                     | ((r_state == ST_WAIT) & (r_cnt == 4'd0));
  assign w_cur_write = w_idle ? mem_write      : r_write;
  assign w_cur_size  = w_idle ? size           : r_size;
  assign w_cur_lane  = w_idle ? addr[1:0]      : r_lane;
  assign w_cur_wdata = w_idle ? wdata          : r_wdata;
  assign w_ram_idx   = w_idle ? w_off[AW+1:2]  : r_idx;
  assign w_we        = (w_go_resp & w_cur_write) ? lane_be(w_cur_size, w_cur_lane) : 4'b0000;

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .i_addr  (w_ram_idx),
    .i_we    (w_we),
    .i_wdata (store_align(w_cur_wdata, w_cur_size)),
    .o_rdata (w_ram_q)
  );

  assign w_ld_data = load_extract(w_ram_q, r_size, r_lane, r_uns);

  // Read data is presented straight from the RAM during RESP and held afterwards.
  assign rdata = ((r_state == ST_RESP) && !r_write) ? w_ld_data : r_rdata;
  assign ready = (r_state == ST_RESP);
  assign error = (r_state == ST_ERR);

  always_ff @(posedge clk) begin
    if (w_idle && w_req) begin
      r_idx   <= w_off[AW+1:2];
      r_lane  <= addr[1:0];
      r_wdata <= wdata;
      r_size  <= size;
      r_uns   <= unsigned_ld;
      r_write <= mem_write;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            if (w_bad) begin
              r_state <= ST_ERR;
            end else if (WAIT_CYCLES > 0) begin
              r_state <= ST_WAIT;
              r_cnt   <= WAIT_LOAD;
            end else begin
              r_state <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) r_state <= ST_RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        ST_RESP: begin
          if (!r_write) r_rdata <= w_ld_data;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
